ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Multi-core arbiter and sequencer for the single shared RAM port.
- Collects instruction and data requests from CPUS cores, grants one requester at a time, and holds the grant until the RAM reports ACCESS or ERROR.
- Routes ramload back to the granted core and drives iwait/dwait.
- Sits between the per-core cache/fetch request signals and the RAM; successor to the single-core combinational memory controller for multicore builds.

Parameters:
- CPUS, 2, number of cores; supported range 1..4.
- STARVE_LIMIT, 8, cycles a pending instruction request may lose before it is promoted to data priority; must be at least 1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  [CPUS]  instruction read request, per core.
- dREN  in  [CPUS]  data read request, per core.
- dWEN  in  [CPUS]  data write request, per core.
- iaddr  in  [CPUS] x word_t  instruction address.
- daddr  in  [CPUS] x word_t  data address.
- dstore  in  [CPUS] x word_t  write data.
- iwait  out  [CPUS]  instruction stall; 0 means the access completes this cycle.
- dwait  out  [CPUS]  data stall.
- iload  out  [CPUS] x word_t  instruction read data.
- dload  out  [CPUS] x word_t  data read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from the RAM.
- ramload  in  word_t  RAM read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  word_t  RAM address.
- ramstore  out  word_t  RAM write data.
- ramerr  out  1  sticky; set when an ERROR ends a granted access.

Behaviour:
- Reset (RST high at an edge):
  - State goes to IDLE.
  - All iwait/dwait = 1; all iload/dload = 0.
  - ramREN = ramWEN = 0; ramaddr = ramstore = 0.
  - ramerr = 0; starvation counters = 0.
  - Round-robin pointer rr = CPUS-1, so core 0 wins the first tie.
- Request classes:
  - Per core, dWEN beats dREN (drive a write, never both enables).
  - Data class (dWEN|dREN) beats instruction class, except a promoted instruction request (counter == STARVE_LIMIT) joins the data class.
  - Within the data class, a core's data request beats its own promoted instruction request.
- Round robin: within the winning class, search cores starting at (rr+1) mod CPUS; the first requesting core wins.
- States:
  - IDLE: RAM enables 0, all waits 1. If any request is pending, register the grant (core, class, kind) and go to HOLD. Otherwise stay in IDLE.
  - HOLD:
    - Drive ramaddr, ramstore, ramREN/ramWEN from the granted core's current inputs.
    - Route ramload to the granted core's iload or dload; every other load output is 0.
    - ramstate == ACCESS: granted wait = 0 this cycle; rr <= granted core; next state IDLE.
    - ramstate == ERROR: all waits stay 1; ramerr <= 1; next state IDLE, where the request is re-arbitrated.
    - FREE or BUSY: stay in HOLD, waits 1.
    - If the granted request deasserts while in HOLD: drop the enables in that same cycle, next state IDLE, no wait pulse.
- Latency: minimum 2 cycles per access (1 arbitration cycle plus 1 HOLD cycle when the RAM returns ACCESS at once). Back-to-back grants always have one IDLE cycle between them.
- Starvation counters, per core:
  - Increment each cycle iREN is high and that core's instruction request is not the current grant.
  - Saturate at STARVE_LIMIT.
  - Clear when that instruction access completes or when iREN is low.
- Reset asserted mid-HOLD: the access is abandoned. The RAM enables drop on the next edge and no wait is released.
- ramerr clears only on reset.

Decomposition:
- Add to cpu_types_pkg:
  - arb_state_t (IDLE, HOLD).
  - req_kind_t (IFETCH, DREAD, DWRITE).
- ramstate_t and word_t already exist there.
- One natural sub-module: rr_picker. It is combinational: request vector plus pointer in, one-hot grant plus valid out. It is instantiated twice, once for the data class and once for the instruction class.

Test Plan:
- Single fetch: core0 iREN=1, iaddr=0x40, RAM gives ACCESS on its first HOLD cycle with ramload=0xDEADBEEF. Required: ramREN=1, ramaddr=0x40; iload[0]=0xDEADBEEF with iwait[0]=0 exactly once, 2 cycles after the request.
- Data beats instruction: core0 iREN, core1 dWEN with daddr=0x80 and dstore=0x1234, both in the same cycle. Required: core1's write is granted first (ramWEN=1, ramstore=0x1234); core0's fetch is served next.
- Round robin: both cores hold dREN continuously, each RAM access takes 2 BUSY cycles then ACCESS. Required: grants alternate 0,1,0,1 and no core gets two consecutive grants.
- Starvation: STARVE_LIMIT=3; core1 iREN held while core0 issues continuous dREN. Required: core1's fetch is granted within 3 grants of being promoted.
- ERROR: RAM returns ERROR during a granted dREN. Required: dwait stays 1, ramerr=1 and stays set, the request is re-granted after the IDLE cycle, then completes on ACCESS.
- Retraction and reset: the granted core drops dREN mid-HOLD. Required: enables drop that cycle, no dwait pulse. Separately, RST mid-HOLD returns every output to its reset value on the next edge.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the multicore RAM arbiter: RAM word/state encodings,
// arbiter FSM states and the kind of request currently granted.
package ram_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    IFETCH = 2'd0,
    DREAD  = 2'd1,
    DWRITE = 2'd2
  } req_kind_t;

  // ACCESS and ERROR both terminate the current RAM transaction
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of per-core request/response signals and the shared RAM port.
// master: the arbiter; slave: the cores and RAM around it.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int CPUS = 2
);

  logic [CPUS-1:0] iREN;
  logic [CPUS-1:0] dREN;
  logic [CPUS-1:0] dWEN;
  word_t           iaddr  [CPUS];
  word_t           daddr  [CPUS];
  word_t           dstore [CPUS];
  logic [CPUS-1:0] iwait;
  logic [CPUS-1:0] dwait;
  word_t           iload  [CPUS];
  word_t           dload  [CPUS];

  ramstate_t       ramstate;
  word_t           ramload;
  logic            ramREN;
  logic            ramWEN;
  word_t           ramaddr;
  word_t           ramstore;
  logic            ramerr;

  modport master (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  modport slave (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester found searching upward
// from ptr+1 (wrapping) gets a one-hot grant.
module ram_arbiter_rr_picker #(
  parameter int CPUS = 2,
  parameter int CW   = 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic [CPUS-1:0] gnt,
  output logic            valid
);

  logic [CW-1:0] idx_s;

  // scan from the core after ptr, ending on ptr itself
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx_s = '0;
    for (int i = 1; i <= CPUS; i++) begin
      idx_s = CW'((int'(ptr) + i) % CPUS);
      if (!valid && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        valid      = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shared RAM port arbiter: per-core fetch and data requests are granted one
// at a time and held until the RAM reports ACCESS or ERROR.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int CPUS         = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic           CLK,
  input logic           RST,
  ram_arbiter_if.master bus
);

  localparam int            CW      = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int            NW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [NW-1:0] LIMIT_C = NW'(STARVE_LIMIT);

  arb_state_t      state_r;
  arb_state_t      state_s;
  logic [CW-1:0]   gnt_core_r;
  req_kind_t       gnt_kind_r;
  logic [CW-1:0]   rr_r;
  logic            ramerr_r;
  logic [NW-1:0]   cnt_r [CPUS];

  logic [CPUS-1:0] data_req_s;
  logic [CPUS-1:0] data_gnt_s;
  logic [CPUS-1:0] inst_gnt_s;
  logic            data_valid_s;
  logic            inst_valid_s;
  logic            any_req_s;
  logic [CW-1:0]   win_core_s;
  req_kind_t       win_kind_s;
  logic            gnt_active_s;
  logic            hold_live_s;

  // data class; a starved fetch is promoted into it
  always_comb begin
    data_req_s = '0;
    for (int c = 0; c < CPUS; c++) begin
      data_req_s[c] = bus.dREN[c] | bus.dWEN[c] | (bus.iREN[c] & (cnt_r[c] == LIMIT_C));
    end
  end

  ram_arbiter_rr_picker #(.CPUS(CPUS), .CW(CW)) u_data_pick (
    .req   (data_req_s),
    .ptr   (rr_r),
    .gnt   (data_gnt_s),
    .valid (data_valid_s)
  );

  ram_arbiter_rr_picker #(.CPUS(CPUS), .CW(CW)) u_inst_pick (
    .req   (bus.iREN),
    .ptr   (rr_r),
    .gnt   (inst_gnt_s),
    .valid (inst_valid_s)
  );

  assign any_req_s = data_valid_s | inst_valid_s;

  // winning core and kind; a core's own data request beats its promoted fetch
  always_comb begin
    win_core_s = '0;
    win_kind_s = IFETCH;
    if (data_valid_s) begin
      for (int c = 0; c < CPUS; c++) begin
        if (data_gnt_s[c]) win_core_s = CW'(c);
      end
      if (bus.dWEN[win_core_s])      win_kind_s = DWRITE;
      else if (bus.dREN[win_core_s]) win_kind_s = DREAD;
      else                           win_kind_s = IFETCH;
    end else begin
      for (int c = 0; c < CPUS; c++) begin
        if (inst_gnt_s[c]) win_core_s = CW'(c);
      end
      win_kind_s = IFETCH;
    end
  end

  // is the granted request still being asserted by its core
  always_comb begin
    case (gnt_kind_r)
      IFETCH:  gnt_active_s = bus.iREN[gnt_core_r];
      DREAD:   gnt_active_s = bus.dREN[gnt_core_r];
      DWRITE:  gnt_active_s = bus.dWEN[gnt_core_r];
      default: gnt_active_s = 1'b0;
    endcase
  end

  assign hold_live_s = (state_r == HOLD) && gnt_active_s;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_s = HOLD;
        else           state_s = IDLE;
      end
      HOLD: begin
        if (!gnt_active_s || ram_done(bus.ramstate)) state_s = IDLE;
        else                                         state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // grant capture, round-robin pointer and sticky error flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt_core_r <= '0;
      gnt_kind_r <= IFETCH;
      rr_r       <= CW'(CPUS - 1);
      ramerr_r   <= 1'b0;
    end else begin
      if (state_r == IDLE && any_req_s) begin
        gnt_core_r <= win_core_s;
        gnt_kind_r <= win_kind_s;
      end
      if (hold_live_s && bus.ramstate == ACCESS) rr_r <= gnt_core_r;
      if (hold_live_s && bus.ramstate == ERROR)  ramerr_r <= 1'b1;
    end
  end

  // per-core fetch starvation counters, saturating at the promotion limit
  always_ff @(posedge CLK) begin
    for (int c = 0; c < CPUS; c++) begin
      if (RST) begin
        cnt_r[c] <= '0;
      end else if (!bus.iREN[c]) begin
        cnt_r[c] <= '0;
      end else if (state_r == HOLD && gnt_kind_r == IFETCH && gnt_core_r == CW'(c)) begin
        if (bus.ramstate == ACCESS) cnt_r[c] <= '0;
        else                        cnt_r[c] <= cnt_r[c];
      end else if (cnt_r[c] != LIMIT_C) begin
        cnt_r[c] <= cnt_r[c] + NW'(1);
      end else begin
        cnt_r[c] <= cnt_r[c];
      end
    end
  end

  // RAM drive, load routing and wait release for the live grant
  always_comb begin
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    for (int c = 0; c < CPUS; c++) begin
      bus.iload[c] = '0;
      bus.dload[c] = '0;
    end
    if (hold_live_s) begin
      case (gnt_kind_r)
        IFETCH: begin
          bus.ramREN               = 1'b1;
          bus.ramaddr              = bus.iaddr[gnt_core_r];
          bus.iload[gnt_core_r]    = bus.ramload;
          bus.iwait[gnt_core_r]    = (bus.ramstate != ACCESS);
        end
        DREAD: begin
          bus.ramREN               = 1'b1;
          bus.ramaddr              = bus.daddr[gnt_core_r];
          bus.dload[gnt_core_r]    = bus.ramload;
          bus.dwait[gnt_core_r]    = (bus.ramstate != ACCESS);
        end
        DWRITE: begin
          bus.ramWEN               = 1'b1;
          bus.ramaddr              = bus.daddr[gnt_core_r];
          bus.ramstore             = bus.dstore[gnt_core_r];
          bus.dload[gnt_core_r]    = bus.ramload;
          bus.dwait[gnt_core_r]    = (bus.ramstate != ACCESS);
        end
        default: begin
          bus.ramREN = 1'b0;
        end
      endcase
    end else begin
      bus.ramREN = 1'b0;
    end
  end

  assign bus.ramerr = ramerr_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized bench for ram_arbiter, checked every cycle against
// a transaction-level model of grants, starvation promotion and error flag.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int NC = 2;
  localparam int SL = 3;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   glog [$];

  // reference model: owner < 0 means no access in progress
  int   m_owner;
  int   m_kind;   // 0 fetch, 1 read, 2 write
  int   m_rr;
  int   m_starve [NC];
  bit   m_err;

  ram_arbiter_if #(.CPUS(NC)) bus ();

  ram_arbiter #(.CPUS(NC), .STARVE_LIMIT(SL)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_live();
    if (m_owner < 0)  return 1'b0;
    if (m_kind == 0)  return bus.iREN[m_owner];
    if (m_kind == 1)  return bus.dREN[m_owner];
    return bus.dWEN[m_owner];
  endfunction

  task automatic clear_inputs();
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    for (int c = 0; c < NC; c++) begin
      bus.iaddr[c] = '0; bus.daddr[c] = '0; bus.dstore[c] = '0;
    end
    bus.ramstate = FREE;
    bus.ramload  = '0;
  endtask

  // compare every output mid-cycle and log completed accesses
  task automatic check_phase();
    logic [NC-1:0] e_iw, e_dw;
    word_t         e_il [NC];
    word_t         e_dl [NC];
    logic          e_ren, e_wen;
    word_t         e_addr, e_st;
    @(negedge clk);
    e_iw = '1; e_dw = '1; e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_st = '0;
    for (int c = 0; c < NC; c++) begin e_il[c] = '0; e_dl[c] = '0; end
    if (model_live()) begin
      if (m_kind == 0) begin
        e_ren = 1'b1;
        e_addr = bus.iaddr[m_owner];
        e_il[m_owner] = bus.ramload;
        e_iw[m_owner] = (bus.ramstate != ACCESS);
      end else begin
        e_addr = bus.daddr[m_owner];
        e_dl[m_owner] = bus.ramload;
        e_dw[m_owner] = (bus.ramstate != ACCESS);
        if (m_kind == 2) begin e_wen = 1'b1; e_st = bus.dstore[m_owner]; end
        else e_ren = 1'b1;
      end
    end
    chk("iwait", 32'(bus.iwait), 32'(e_iw));
    chk("dwait", 32'(bus.dwait), 32'(e_dw));
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("iload%0d", c), bus.iload[c], e_il[c]);
      chk($sformatf("dload%0d", c), bus.dload[c], e_dl[c]);
    end
    chk("ramREN", 32'(bus.ramREN), 32'(e_ren));
    chk("ramWEN", 32'(bus.ramWEN), 32'(e_wen));
    chk("ramaddr", bus.ramaddr, e_addr);
    chk("ramstore", bus.ramstore, e_st);
    chk("ramerr", 32'(bus.ramerr), 32'(m_err));
    for (int c = 0; c < NC; c++) begin
      if (bus.iwait[c] === 1'b0) glog.push_back(c + 10);
      if (bus.dwait[c] === 1'b0) glog.push_back(c);
    end
  endtask

  // apply the edge to the model, then move to just after the clock edge
  task automatic advance();
    bit live;
    int nxt;
    int win;
    int k;
    live = model_live();
    if (rst) begin
      m_owner = -1; m_kind = 0; m_rr = NC - 1; m_err = 1'b0;
      for (int c = 0; c < NC; c++) m_starve[c] = 0;
    end else begin
      nxt = m_owner;
      k   = m_kind;
      if (m_owner >= 0) begin
        if (!live || bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
          if (live && bus.ramstate == ACCESS) m_rr = m_owner;
          if (live && bus.ramstate == ERROR)  m_err = 1'b1;
          nxt = -1;
        end
      end else begin
        win = -1;
        for (int i = 1; i <= NC; i++) begin
          int c = (m_rr + i) % NC;
          if (win < 0 && (bus.dREN[c] || bus.dWEN[c] || (bus.iREN[c] && m_starve[c] == SL))) win = c;
        end
        if (win >= 0) begin
          k = bus.dWEN[win] ? 2 : (bus.dREN[win] ? 1 : 0);
        end else begin
          for (int i = 1; i <= NC; i++) begin
            int c = (m_rr + i) % NC;
            if (win < 0 && bus.iREN[c]) win = c;
          end
          k = 0;
        end
        nxt = win;
      end
      for (int c = 0; c < NC; c++) begin
        if (!bus.iREN[c]) m_starve[c] = 0;
        else if (m_owner == c && m_kind == 0) begin
          if (bus.ramstate == ACCESS) m_starve[c] = 0;
        end else if (m_starve[c] < SL) m_starve[c]++;
      end
      m_owner = nxt;
      m_kind  = k;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    check_phase();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    advance();
    check_phase();
    advance();
    rst = 1'b0;
    glog.delete();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_owner  = -1;
    m_kind   = 0;
    m_rr     = NC - 1;
    m_err    = 1'b0;
    for (int c = 0; c < NC; c++) m_starve[c] = 0;

    // single fetch
    do_reset();
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h0000_0040;
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'hDEAD_BEEF;
    check_phase();
    chk("fetch_ren", 32'(bus.ramREN), 32'd1);
    chk("fetch_addr", bus.ramaddr, 32'h0000_0040);
    chk("fetch_load", bus.iload[0], 32'hDEAD_BEEF);
    chk("fetch_wait", 32'(bus.iwait[0]), 32'd0);
    advance();
    bus.iREN[0] = 1'b0;
    step();
    chk("fetch_pulses", 32'(glog.size()), 32'd1);

    // data beats instruction
    do_reset();
    bus.ramstate = ACCESS;
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h0000_0100;
    bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h0000_0080; bus.dstore[1] = 32'h0000_1234;
    step();
    check_phase();
    chk("dbi_wen", 32'(bus.ramWEN), 32'd1);
    chk("dbi_store", bus.ramstore, 32'h0000_1234);
    chk("dbi_addr", bus.ramaddr, 32'h0000_0080);
    advance();
    bus.dWEN[1] = 1'b0;
    step();
    step();
    bus.iREN[0] = 1'b0;
    chk("dbi_n", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("dbi_first", 32'(glog[0]), 32'd1);
      chk("dbi_second", 32'(glog[1]), 32'd10);
    end

    // round robin with slow RAM
    do_reset();
    bus.dREN = '1;
    bus.daddr[0] = 32'h0000_1000; bus.daddr[1] = 32'h0000_2000;
    for (int g = 0; g < 4; g++) begin
      bus.ramstate = FREE;   step();
      bus.ramstate = BUSY;   step();
      step();
      bus.ramstate = ACCESS; step();
    end
    bus.dREN = '0;
    chk("rr_n", 32'(glog.size()), 32'd4);
    for (int g = 0; g < 4 && g < glog.size(); g++) chk($sformatf("rr_grant%0d", g), 32'(glog[g]), 32'(g % 2));

    // starvation promotion
    do_reset();
    bus.ramstate = ACCESS;
    bus.dREN[0] = 1'b1; bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h0000_0444;
    for (int i = 0; i < 6; i++) step();
    bus.dREN = '0; bus.iREN = '0;
    chk("starve_n", 32'(glog.size()), 32'd3);
    if (glog.size() >= 3) chk("starve_fetch", 32'(glog[2]), 32'd11);

    // ERROR then retry
    do_reset();
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h0000_0C00;
    step();
    bus.ramstate = ERROR;
    check_phase();
    chk("err_dwait", 32'(bus.dwait[0]), 32'd1);
    advance();
    bus.ramstate = FREE;
    check_phase();
    chk("err_flag", 32'(bus.ramerr), 32'd1);
    chk("err_idle_ren", 32'(bus.ramREN), 32'd0);
    advance();
    bus.ramstate = ACCESS;
    check_phase();
    chk("err_retry", 32'(bus.dwait[0]), 32'd0);
    advance();
    bus.dREN[0] = 1'b0;
    check_phase();
    chk("err_sticky", 32'(bus.ramerr), 32'd1);
    advance();

    // retraction mid-HOLD
    glog.delete();
    bus.dREN[0] = 1'b1; bus.ramstate = FREE;
    step();
    bus.ramstate = BUSY;
    step();
    bus.dREN[0] = 1'b0; bus.ramstate = ACCESS;
    check_phase();
    chk("retract_ren", 32'(bus.ramREN), 32'd0);
    chk("retract_dwait", 32'(bus.dwait[0]), 32'd1);
    advance();
    step();
    chk("retract_pulses", 32'(glog.size()), 32'd0);

    // reset mid-HOLD
    bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h0000_0900; bus.ramstate = BUSY;
    step();
    rst = 1'b1;
    check_phase();
    chk("rsthold_ren", 32'(bus.ramREN), 32'd1);
    advance();
    check_phase();
    chk("rst_ren", 32'(bus.ramREN), 32'd0);
    chk("rst_addr", bus.ramaddr, 32'd0);
    chk("rst_err", 32'(bus.ramerr), 32'd0);
    chk("rst_dwait", 32'(bus.dwait), 32'd3);
    advance();
    rst = 1'b0;
    clear_inputs();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.iREN[c] = 1'($urandom_range(0, 1));
          bus.dREN[c] = 1'($urandom_range(0, 1));
          bus.dWEN[c] = ($urandom_range(0, 3) == 0);
        end
        bus.iaddr[c]  = $urandom;
        bus.daddr[c]  = $urandom;
        bus.dstore[c] = $urandom;
      end
      bus.ramstate = ramstate_t'(2'($urandom_range(0, 3)));
      bus.ramload  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
